// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its write buffer.
package dmem_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BYTE_OFF_W = 3;
    // Widest word index any instance may use; narrower instances leave the top bits zero.
    localparam int unsigned IDX_MAX_W  = 32;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] index;
        logic [DATA_W-1:0]    data;
    } wbEntry_t;

    function automatic logic [IDX_MAX_W-1:0] wordIndex(input logic [DATA_W-1:0] byteAddr,
                                                       input int unsigned addrW);
        return IDX_MAX_W'((byteAddr >> BYTE_OFF_W) & ((DATA_W'(1) << addrW) - DATA_W'(1)));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU MEM-stage data port (address/command side) plus write-buffer status.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4
) ();

    logic [DATA_W-1:0]         daddrbus;
    logic                      load;
    logic                      store;
    logic [$clog2(WB_DEPTH):0] wb_count;
    logic                      wb_full;
    logic                      err;

    modport master (
        output daddrbus, load, store,
        input  wb_count, wb_full, err
    );

    modport slave (
        input  daddrbus, load, store,
        output wb_count, wb_full, err
    );

endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO with a combinational associative lookup (newest matching entry wins).
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  wbEntry_t                  pushEntry_i,
    input  logic                      pop_i,
    output wbEntry_t                  headEntry_o,
    output logic [$clog2(WB_DEPTH):0] count_o,
    output logic                      full_o,
    input  logic [IDX_MAX_W-1:0]      lookupIndex_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         hitData_o
);

    localparam int unsigned PTR_W = $clog2(WB_DEPTH);

    wbEntry_t         entries_q [WB_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic             doPop;

    assign doPop = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PTR_W'(1);
            if (doPop)  head_q <= head_q + PTR_W'(1);
            case ({push_i, doPop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // When full, push and pop hit the same slot; the popped entry is read before the edge.
    always_ff @(posedge clk) begin
        if (push_i) entries_q[tail_q] <= pushEntry_i;
    end

    assign headEntry_o = entries_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == (PTR_W+1)'(WB_DEPTH));

    // Walk oldest to newest so the last match overrides earlier ones.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot      = '0;
        hit_o     = 1'b0;
        hitData_o = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (entries_q[slot].index == lookupIndex_i)) begin
                hit_o     = 1'b1;
                hitData_o = entries_q[slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency loads with store bypass, posted stores drained on
// non-load cycles into a single-port word array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_responder_if.slave        bus,
    inout  wire  [DATA_W-1:0]      databus
);

    logic [IDX_MAX_W-1:0]      index;
    logic                      isLoad;
    logic                      doPop;
    logic                      hit;
    logic [DATA_W-1:0]         hitData;
    logic [DATA_W-1:0]         rdData;
    wbEntry_t                  pushEntry;
    wbEntry_t                  headEntry;
    logic [$clog2(WB_DEPTH):0] count;
    logic                      full;
    logic                      err_q;
    logic                      unusedHeadIdx;
    logic [DATA_W-1:0]         mem [2**ADDR_W];

    assign index     = wordIndex(bus.daddrbus, ADDR_W);
    assign isLoad    = bus.load && !bus.store;
    // Reset discards buffered stores, so nothing may reach the array on a reset edge.
    assign doPop     = !reset && !bus.load && (count != '0);
    assign pushEntry = '{index: index, data: databus};

    dmem_write_buffer #(
        .WB_DEPTH (WB_DEPTH)
    ) u_write_buffer (
        .clk           (clk),
        .reset         (reset),
        .push_i        (bus.store),
        .pushEntry_i   (pushEntry),
        .pop_i         (doPop),
        .headEntry_o   (headEntry),
        .count_o       (count),
        .full_o        (full),
        .lookupIndex_i (index),
        .hit_o         (hit),
        .hitData_o     (hitData)
    );

    always_ff @(posedge clk) begin
        if (doPop) mem[headEntry.index[ADDR_W-1:0]] <= headEntry.data;
    end

    assign rdData  = hit ? hitData : mem[index[ADDR_W-1:0]];
    assign databus = isLoad ? rdData : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.load && bus.store) begin
            err_q <= 1'b1;
        end
    end

    // Index bits above ADDR_W are always zero for stored entries.
    assign unusedHeadIdx = ^headEntry.index;

    assign bus.wb_count = count;
    assign bus.wb_full  = full;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, then random traffic against a queue model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned NWORDS   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if #(.WB_DEPTH(WB_DEPTH)) dif ();

    wire  [63:0] databus;
    logic        tbDrv;
    logic [63:0] tbData;
    assign databus = tbDrv ? tbData : 'z;

    dmem_responder #(
        .ADDR_W   (ADDR_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (dif),
        .databus (databus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, sample databus mid-cycle, return just after the rising edge.
    task automatic applyCycle(input bit r, input logic [63:0] a, input bit l, input bit s,
                              input logic [63:0] d, output logic [63:0] busSeen);
        reset        = r;
        dif.daddrbus = a;
        dif.load     = l;
        dif.store    = s;
        tbData       = d;
        tbDrv        = !(l && !s);
        @(negedge clk);
        busSeen = databus;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        bit          rst;
        logic [63:0] addr;
        bit          ld;
        bit          st;
        logic [63:0] data;
        bit          chkBus;
        logic [63:0] expBus;
        int          expCnt;
        bit          expFull;
        bit          expErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit r, input logic [63:0] a, input bit l,
                                input bit s, input logic [63:0] d, input bit cb,
                                input logic [63:0] eb, input int ec, input bit ef, input bit ee);
        vec_t v;
        v = '{name: n, rst: r, addr: a, ld: l, st: s, data: d, chkBus: cb, expBus: eb,
              expCnt: ec, expFull: ef, expErr: ee};
        return v;
    endfunction

    // Reference model: FIFO of pending stores plus a word array of known values.
    typedef struct {
        int          idx;
        logic [63:0] data;
    } item_t;

    item_t       refQ[$];
    logic [63:0] refMem [NWORDS];
    bit          refKnown [NWORDS];
    bit          refErr;

    function automatic int idxOf(input logic [63:0] a);
        return int'((a >> 3) % 64'(NWORDS));
    endfunction

    function automatic logic [63:0] modelRead(input int idx, output bit known);
        for (int k = refQ.size() - 1; k >= 0; k--) begin
            if (refQ[k].idx == idx) begin
                known = 1'b1;
                return refQ[k].data;
            end
        end
        known = refKnown[idx];
        return refMem[idx];
    endfunction

    task automatic modelCycle(input bit l, input bit s, input logic [63:0] a,
                              input logic [63:0] d);
        logic [63:0] seen;
        logic [63:0] expBus;
        bit          known;
        item_t       e;
        known  = 1'b1;
        expBus = d;
        if (l && !s) expBus = modelRead(idxOf(a), known);
        applyCycle(1'b0, a, l, s, d, seen);
        if (known) check("rnd_bus", seen, expBus);
        if (!l && refQ.size() > 0) begin
            e = refQ.pop_front();
            refMem[e.idx]   = e.data;
            refKnown[e.idx] = 1'b1;
        end
        if (s) refQ.push_back('{idx: idxOf(a), data: d});
        if (l && s) refErr = 1'b1;
        check("rnd_count", 64'(dif.wb_count), 64'(refQ.size()));
        check("rnd_full", 64'(dif.wb_full), 64'(refQ.size() == WB_DEPTH));
        check("rnd_err", 64'(dif.err), 64'(refErr));
    endtask

    function automatic logic [63:0] randAddr(input int idx);
        logic [63:0] hi;
        hi = {$urandom, $urandom};
        return (hi << (ADDR_W + 3)) | (64'(idx) << 3) | 64'($urandom_range(0, 7));
    endfunction

    localparam logic [63:0] V1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] VA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] VB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] VC = 64'hCCCC_1234_5678_000C;
    localparam logic [63:0] D0 = 64'hD000_0000_0000_00D0;
    localparam logic [63:0] D1 = 64'hD111_0000_0000_00D1;
    localparam logic [63:0] D2 = 64'hD222_0000_0000_00D2;
    localparam logic [63:0] D3 = 64'hD333_0000_0000_00D3;
    localparam logic [63:0] VX = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VY = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] VZ = 64'h7777_8888_9999_0000;
    localparam logic [63:0] VW = 64'h3C3C_C3C3_0F0F_F0F0;
    localparam logic [63:0] PI = 64'h5A5A_A5A5_5A5A_A5A5;
    localparam logic [63:0] AL = 64'h40 + (64'd1 << (ADDR_W + 3));

    initial begin
        logic [63:0] seen;
        int          op;
        int          idx;

        dif.daddrbus = '0;
        dif.load     = 1'b0;
        dif.store    = 1'b0;
        tbDrv        = 1'b0;
        tbData       = '0;
        reset        = 1'b1;
        for (int i = 0; i < NWORDS; i++) refKnown[i] = 1'b0;
        refErr = 1'b0;

        applyCycle(1'b1, 64'h0, 1'b0, 1'b0, PI, seen);
        applyCycle(1'b1, 64'h0, 1'b0, 1'b0, PI, seen);
        check("reset_count", 64'(dif.wb_count), 64'd0);
        check("reset_full", 64'(dif.wb_full), 64'd0);
        check("reset_err", 64'(dif.err), 64'd0);

        //            name            rst addr   ld st data chk expBus cnt full err
        vecs.push_back(mk("byp_store",  0, 'h40,  0, 1, V1, 1, V1, 1, 0, 0));
        vecs.push_back(mk("byp_load",   0, 'h40,  1, 0, PI, 1, V1, 1, 0, 0));
        vecs.push_back(mk("byp_idle",   0, 'h0,   0, 0, PI, 1, PI, 0, 0, 0));
        vecs.push_back(mk("byp_arr",    0, 'h40,  1, 0, PI, 1, V1, 0, 0, 0));
        vecs.push_back(mk("nm_storeA",  0, 'h80,  0, 1, VA, 1, VA, 1, 0, 0));
        vecs.push_back(mk("nm_ldstB",   0, 'h80,  1, 1, VB, 1, VB, 2, 0, 1));
        vecs.push_back(mk("nm_load1",   0, 'h80,  1, 0, PI, 1, VB, 2, 0, 1));
        vecs.push_back(mk("nm_load2",   0, 'h80,  1, 0, PI, 1, VB, 2, 0, 1));
        vecs.push_back(mk("nm_idle1",   0, 'h0,   0, 0, PI, 1, PI, 1, 0, 1));
        vecs.push_back(mk("nm_idle2",   0, 'h0,   0, 0, PI, 1, PI, 0, 0, 1));
        vecs.push_back(mk("nm_arr",     0, 'h80,  1, 0, PI, 1, VB, 0, 0, 1));
        vecs.push_back(mk("rst1",       1, 'h0,   0, 0, PI, 0, 0,  0, 0, 0));
        vecs.push_back(mk("blk_fill0",  0, 'h200, 1, 1, D0, 1, D0, 1, 0, 1));
        vecs.push_back(mk("blk_fill1",  0, 'h208, 1, 1, D1, 1, D1, 2, 0, 1));
        vecs.push_back(mk("blk_fill2",  0, 'h210, 1, 1, D2, 1, D2, 3, 0, 1));
        vecs.push_back(mk("blk_fill3",  0, 'h218, 1, 1, D3, 1, D3, 4, 1, 1));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("blk_load", 0, 'h40, 1, 0, PI, 1, V1, 4, 1, 1));
        vecs.push_back(mk("full_store", 0, 'h100, 0, 1, VC, 1, VC, 4, 1, 1));
        vecs.push_back(mk("drain3",     0, 'h0,   0, 0, PI, 1, PI, 3, 0, 1));
        vecs.push_back(mk("drain2",     0, 'h0,   0, 0, PI, 1, PI, 2, 0, 1));
        vecs.push_back(mk("drain1",     0, 'h0,   0, 0, PI, 1, PI, 1, 0, 1));
        vecs.push_back(mk("drain0",     0, 'h0,   0, 0, PI, 1, PI, 0, 0, 1));
        vecs.push_back(mk("full_ldC",   0, 'h100, 1, 0, PI, 1, VC, 0, 0, 1));
        vecs.push_back(mk("full_ldD3",  0, 'h218, 1, 0, PI, 1, D3, 0, 0, 1));
        vecs.push_back(mk("full_ldD0",  0, 'h200, 1, 0, PI, 1, D0, 0, 0, 1));
        vecs.push_back(mk("full_ldD1",  0, 'h208, 1, 0, PI, 1, D1, 0, 0, 1));
        vecs.push_back(mk("rst2",       1, 'h0,   0, 0, PI, 0, 0,  0, 0, 0));
        vecs.push_back(mk("rm_storeX",  0, 'h08,  0, 1, VX, 1, VX, 1, 0, 0));
        vecs.push_back(mk("rm_idle",    0, 'h0,   0, 0, PI, 1, PI, 0, 0, 0));
        vecs.push_back(mk("rm_storeY",  0, 'h08,  0, 1, VY, 1, VY, 1, 0, 0));
        vecs.push_back(mk("rm_reset",   1, 'h0,   0, 0, PI, 0, 0,  0, 0, 0));
        vecs.push_back(mk("rm_loadX",   0, 'h08,  1, 0, PI, 1, VX, 0, 0, 0));
        vecs.push_back(mk("al_store",   0, AL,    0, 1, VZ, 1, VZ, 1, 0, 0));
        vecs.push_back(mk("al_byp",     0, 'h40,  1, 0, PI, 1, VZ, 1, 0, 0));
        vecs.push_back(mk("al_idle",    0, 'h0,   0, 0, PI, 1, PI, 0, 0, 0));
        vecs.push_back(mk("al_arr",     0, 'h47,  1, 0, PI, 1, VZ, 0, 0, 0));
        vecs.push_back(mk("pe_ldst",    0, 'h300, 1, 1, VW, 1, VW, 1, 0, 1));
        vecs.push_back(mk("pe_idle1",   0, 'h0,   0, 0, PI, 1, PI, 0, 0, 1));
        vecs.push_back(mk("pe_idle2",   0, 'h0,   0, 0, PI, 1, PI, 0, 0, 1));
        vecs.push_back(mk("pe_load",    0, 'h300, 1, 0, PI, 1, VW, 0, 0, 1));
        vecs.push_back(mk("pe_reset",   1, 'h0,   0, 0, PI, 0, 0,  0, 0, 0));

        foreach (vecs[i]) begin
            applyCycle(vecs[i].rst, vecs[i].addr, vecs[i].ld, vecs[i].st, vecs[i].data, seen);
            if (vecs[i].chkBus) check({vecs[i].name, "_bus"}, seen, vecs[i].expBus);
            check({vecs[i].name, "_count"}, 64'(dif.wb_count), 64'(vecs[i].expCnt));
            check({vecs[i].name, "_full"}, 64'(dif.wb_full), 64'(vecs[i].expFull));
            check({vecs[i].name, "_err"}, 64'(dif.err), 64'(vecs[i].expErr));
        end

        // Random traffic over a small aliased index set, checked against the queue model.
        applyCycle(1'b1, 64'h0, 1'b0, 1'b0, PI, seen);
        refQ.delete();
        refErr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            modelCycle(1'b0, 1'b1, randAddr(k * 37 + 5), {$urandom, $urandom});
            modelCycle(1'b0, 1'b0, 64'h0, PI);
        end
        for (int n = 0; n < 400; n++) begin
            op  = int'($urandom_range(0, 99));
            idx = int'($urandom_range(0, 7)) * 37 + 5;
            if (op < 40) begin
                modelCycle(1'b1, 1'b0, randAddr(idx), PI);
            end else if (op < 70) begin
                modelCycle(1'b0, 1'b1, randAddr(idx), {$urandom, $urandom});
            end else if (op < 90 || refQ.size() == WB_DEPTH) begin
                modelCycle(1'b0, 1'b0, randAddr(idx), {$urandom, $urandom});
            end else begin
                modelCycle(1'b1, 1'b1, randAddr(idx), {$urandom, $urandom});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
